// File: rtl/piso_serializer_param.sv
// Parallel-in / serial-out shifter with a one-word holding buffer.
// A word is emitted one bit per enabled cycle, starting one cycle after it is
// accepted. A second word may wait in the buffer, so back-to-back words leave
// no idle gap on the serial line.
module piso_serializer_param #(
    parameter int   DATA_WIDTH = 8,    // 2..64
    parameter int   LSB_FIRST  = 0,    // 0: MSB first, 1: LSB first
    parameter logic IDLE_LEVEL = 1'b0  // line level while no valid bit
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Data_Valid_In,
    output logic                  Data_Ready_Out,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Last_Bit_Out,
    output logic                  Busy_Out
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  buf_full;

    logic                  xfer;
    logic                  terminal;
    logic                  load_new;
    logic                  load_buf;
    logic                  advance;
    logic                  go_idle;
    logic                  buf_write;
    logic [DATA_WIDTH-1:0] load_word;
    logic [DATA_WIDTH-1:0] shifted;

    // Bit that leaves the word first in the selected order.
    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
    endfunction

    // Word with its head bit consumed, next bit moved to the head position.
    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    // Ready drops while the buffer holds a word, so at most one word waits.
    assign Data_Ready_Out = Enable_In & ~Reset_In & ~buf_full;
    assign xfer           = Data_Valid_In & Data_Ready_Out;
    assign terminal       = (state == SHIFT) && (bit_cnt == LAST_CNT);
    assign load_word      = load_buf ? buf_data : Parallel_Data_In;
    assign shifted        = shift_word(shift_reg);
    assign Busy_Out       = (state == SHIFT) | buf_full;

    // Next state and datapath controls; nothing moves while disabled.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        load_new   = 1'b0;
        load_buf   = 1'b0;
        advance    = 1'b0;
        go_idle    = 1'b0;
        buf_write  = 1'b0;
        if (Enable_In) begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        load_new   = 1'b1;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (terminal) begin
                        // Buffered word has priority; a same-edge transfer
                        // cannot coexist with it because ready is low.
                        if (buf_full) begin
                            load_buf = 1'b1;
                        end else if (xfer) begin
                            load_new = 1'b1;
                        end else begin
                            go_idle    = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        advance   = 1'b1;
                        buf_write = xfer;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register; reset wins over enable.
    always_ff @(posedge Clk_In) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (Reset_In) state <= IDLE;
        else          state <= state_next;
    end

    // Shifter, counter, buffer flag and registered serial outputs.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            shift_reg        <= '0;
            bit_cnt          <= '0;
            buf_full         <= 1'b0;
            Serial_Data_Out  <= IDLE_LEVEL;
            Serial_Valid_Out <= 1'b0;
            Last_Bit_Out     <= 1'b0;
        end else if (Enable_In) begin
            if (load_new || load_buf) begin
                shift_reg        <= load_word;
                bit_cnt          <= '0;
                Serial_Data_Out  <= head_bit(load_word);
                Serial_Valid_Out <= 1'b1;
                Last_Bit_Out     <= 1'b0;
            end else if (advance) begin
                shift_reg        <= shifted;
                bit_cnt          <= bit_cnt + 1'b1;
                Serial_Data_Out  <= head_bit(shifted);
                Last_Bit_Out     <= ((bit_cnt + 1'b1) == LAST_CNT);
            end else if (go_idle) begin
                bit_cnt          <= '0;
                Serial_Data_Out  <= IDLE_LEVEL;
                Serial_Valid_Out <= 1'b0;
                Last_Bit_Out     <= 1'b0;
            end

            if (load_buf)       buf_full <= 1'b0;
            else if (buf_write) buf_full <= 1'b1;
        end
    end

    // Holding buffer contents; only meaningful while buf_full is set.
    always_ff @(posedge Clk_In) begin
        // NOTE: the buffer data is not reset; the full flag alone decides
        // whether it is ever read, so clearing it would add nothing.
        if (Enable_In && buf_write) buf_data <= Parallel_Data_In;
    end

endmodule

// File: tb/tb_piso_serializer_param.sv
// Bench for piso_serializer_param: three instances (8-bit MSB-first, 8-bit
// LSB-first, 16-bit MSB-first idling high). Accepted words push their expected
// bit streams into per-instance queues; monitors pop and compare each bit.
module tb_piso_serializer_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid8;
    logic        valid16;
    logic [7:0]  data8;
    logic [15:0] data16;

    logic rdy0, sd0, sv0, sl0, busy0;
    logic rdy1, sd1, sv1, sl1, busy1;
    logic rdy2, sd2, sv2, sl2, busy2;

    int n_total = 0;
    int n_bad   = 0;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic [1:0] q2[$];
    int         run0 = 0;
    int         runs0[$];

    always #5 clk = ~clk;

    piso_serializer_param #(.DATA_WIDTH(8), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_msb (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Data_Valid_In(valid8),
        .Data_Ready_Out(rdy0), .Parallel_Data_In(data8), .Serial_Data_Out(sd0),
        .Serial_Valid_Out(sv0), .Last_Bit_Out(sl0), .Busy_Out(busy0));

    piso_serializer_param #(.DATA_WIDTH(8), .LSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_lsb (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Data_Valid_In(valid8),
        .Data_Ready_Out(rdy1), .Parallel_Data_In(data8), .Serial_Data_Out(sd1),
        .Serial_Valid_Out(sv1), .Last_Bit_Out(sl1), .Busy_Out(busy1));

    piso_serializer_param #(.DATA_WIDTH(16), .LSB_FIRST(0), .IDLE_LEVEL(1'b1)) u_w16 (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Data_Valid_In(valid16),
        .Data_Ready_Out(rdy2), .Parallel_Data_In(data16), .Serial_Data_Out(sd2),
        .Serial_Valid_Out(sv2), .Last_Bit_Out(sl2), .Busy_Out(busy2));

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors sample mid-low-phase, after stimulus has settled for the next edge.
    always @(negedge clk) begin
        logic [1:0] e;
        #2;
        if (sv0) run0++;
        else if (run0 != 0) begin runs0.push_back(run0); run0 = 0; end
        if (!rst && en && sv0) begin
            if (q0.size() == 0) check("msb stray valid", int'(sv0), 0);
            else begin
                e = q0.pop_front();
                check("msb data", int'(sd0), int'(e[1]));
                check("msb last", int'(sl0), int'(e[0]));
            end
        end else if (!sv0) begin
            check("msb idle data", int'(sd0), 0);
            check("msb idle last", int'(sl0), 0);
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        #2;
        if (!rst && en && sv1) begin
            if (q1.size() == 0) check("lsb stray valid", int'(sv1), 0);
            else begin
                e = q1.pop_front();
                check("lsb data", int'(sd1), int'(e[1]));
                check("lsb last", int'(sl1), int'(e[0]));
            end
        end else if (!sv1) begin
            check("lsb idle data", int'(sd1), 0);
            check("lsb idle last", int'(sl1), 0);
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        #2;
        if (!rst && en && sv2) begin
            if (q2.size() == 0) check("w16 stray valid", int'(sv2), 0);
            else begin
                e = q2.pop_front();
                check("w16 data", int'(sd2), int'(e[1]));
                check("w16 last", int'(sl2), int'(e[0]));
            end
        end else if (!sv2) begin
            check("w16 idle data", int'(sd2), 1);
            check("w16 idle last", int'(sl2), 0);
        end
    end

    // Present a word to both 8-bit instances and hold it until accepted.
    task automatic send8(input logic [7:0] w);
        int n = 0;
        @(negedge clk);
        valid8 = 1'b1;
        data8  = w;
        #1;
        while (!rdy0 && n < 100) begin @(negedge clk); #1; n++; end
        if (!rdy0) begin check("send8 handshake", int'(rdy0), 1); return; end
        for (int i = 7; i >= 0; i--) q0.push_back({w[i], i == 0});
        for (int i = 0; i < 8; i++)  q1.push_back({w[i], i == 7});
        @(posedge clk);
    endtask

    task automatic idle8();
        @(negedge clk);
        valid8 = 1'b0;
        data8  = 8'hE7;
    endtask

    task automatic send16(input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        valid16 = 1'b1;
        data16  = w;
        #1;
        while (!rdy2 && n < 100) begin @(negedge clk); #1; n++; end
        if (!rdy2) begin check("send16 handshake", int'(rdy2), 1); return; end
        for (int i = 15; i >= 0; i--) q2.push_back({w[i], i == 0});
        @(posedge clk);
        @(negedge clk);
        valid16 = 1'b0;
        data16  = 16'h5A5A;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain pending bits", q0.size() + q1.size() + q2.size(), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; valid8 = 1'b0; valid16 = 1'b0;
        data8 = 8'h00; data16 = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("ready in reset", int'(rdy0), 0);
        check("valid in reset", int'(sv0), 0);
        check("busy in reset", int'(busy0), 0);
        check("w16 idle level in reset", int'(sd2), 1);
        rst = 1'b0;
        #1;
        check("ready after reset", int'(rdy0), 1);

        // Single word, 1-cycle latency, last on cycle 8, idle afterwards
        send8(8'hA5);
        idle8();
        repeat (7) @(negedge clk);
        #1;
        check("A5 last on cycle 8", int'(sl0), 1);
        check("A5 busy on cycle 8", int'(busy0), 1);
        @(negedge clk); #1;
        check("A5 busy after", int'(busy0), 0);
        check("A5 valid after", int'(sv0), 0);
        check("A5 lsb busy after", int'(busy1), 0);

        // Back-to-back words with valid held high
        send8(8'hFF);
        send8(8'h00);
        @(negedge clk); #1;
        check("b2b ready while buffer full", int'(rdy0), 0);
        check("b2b busy", int'(busy0), 1);
        send8(8'h81);
        idle8();
        drain();
        repeat (2) @(negedge clk);
        #3;
        check("b2b contiguous valid run", (runs0.size() != 0) ? runs0[runs0.size()-1] : 0, 24);

        // Enable dropped for 3 cycles after bit 3 of C3
        send8(8'hC3);
        idle8();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            en = 1'b0;
            #1;
            check("freeze valid", int'(sv0), 1);
            check("freeze msb data", int'(sd0), 0);
            check("freeze lsb data", int'(sd1), 0);
            check("freeze ready", int'(rdy0), 0);
            check("freeze busy", int'(busy0), 1);
        end
        @(negedge clk);
        en = 1'b1;
        drain();

        // Reset during bit 5 with a word waiting in the buffer
        send8(8'h3C);
        send8(8'h5A);
        idle8();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("busy before reset", int'(busy0), 1);
        check("ready low while reset high", int'(rdy0), 0);
        @(posedge clk); #1;
        q0.delete();
        q1.delete();
        @(negedge clk); #1;
        check("reset mid-word valid", int'(sv0), 0);
        check("reset mid-word data", int'(sd0), 0);
        check("reset mid-word busy", int'(busy0), 0);
        check("reset mid-word lsb valid", int'(sv1), 0);
        rst = 1'b0;
        #1;
        check("ready first cycle after reset", int'(rdy0), 1);
        repeat (10) @(negedge clk);

        // 16-bit instance idling high
        #1;
        check("w16 idle before", int'(sd2), 1);
        send16(16'h8001);
        drain();
        repeat (2) @(negedge clk);
        #1;
        check("w16 idle after", int'(sd2), 1);
        check("w16 valid after", int'(sv2), 0);
        check("w16 busy after", int'(busy2), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
